maxpool2x2_stream: RTL

- Streaming 2x2, stride-2 max-pool stage that sits directly downstream of Layer6.
- Consumes Layer6's raster-order pixel stream. Each accepted beat is one pixel holding CHANNEL packed IEEE-754 fp32 words.
- Emits one pooled pixel per 2x2 window, in raster order.
- Output uses the same Data/Valid beat format, so the next conv layer can attach unchanged.

---
 rtl/pool_pkg.sv | 12 +
 rtl/pool_fp32_max.sv | 22 ++
 rtl/maxpool2x2_stream.sv | 109 ++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared constants and helpers for the fp32 2x2 max-pool stage.
package pool_pkg;

    localparam int FP32_W   = 32;
    localparam int SIGN_BIT = 31;

    // Pooled pixels produced per frame by a 2x2, stride-2 window.
    function automatic int pooled_count(input int width, input int height);
        return (width / 2) * (height / 2);
    endfunction

endpackage

// File: rtl/pool_fp32_max.sv
// Combinational max of two fp32 bit patterns using a sign/magnitude ordering.
module pool_fp32_max
    import pool_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);

    // +0 beats -0; NaN/Inf are ordered purely by their bit patterns.
    always_comb begin
        y = a;
        if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            y = a[SIGN_BIT] ? b : a;
        end else if (!a[SIGN_BIT]) begin
            y = (b[SIGN_BIT-1:0] > a[SIGN_BIT-1:0]) ? b : a;
        end else begin
            y = (b[SIGN_BIT-1:0] < a[SIGN_BIT-1:0]) ? b : a;
        end
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over raster-order pixels of packed fp32 channels.
module maxpool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNEL    = 128,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Valid_In,
    input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
    output logic [DATA_WIDHT*CHANNEL-1:0] Data_Out,
    output logic                          Valid_Out,
    output logic                          Frame_Done
);

    localparam int PIX_W  = DATA_WIDHT * CHANNEL;
    localparam int HALF_W = IMG_WIDHT / 2;
    localparam int COL_W  = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    if (DATA_WIDHT != FP32_W) begin : g_bad_width
        $error("maxpool2x2_stream: only 32-bit channel words are supported");
    end
    if ((IMG_WIDHT % 2) != 0) begin : g_bad_img_width
        $error("maxpool2x2_stream: IMG_WIDHT must be even");
    end
    if ((IMG_HEIGHT % 2) != 0) begin : g_bad_img_height
        $error("maxpool2x2_stream: IMG_HEIGHT must be even");
    end
    if (pooled_count(IMG_WIDHT, IMG_HEIGHT) < 1) begin : g_bad_frame
        $error("maxpool2x2_stream: frame must hold at least one 2x2 window");
    end

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [PIX_W-1:0] h_reg;
    logic [PIX_W-1:0] hmax;
    logic [PIX_W-1:0] vmax;
    logic [PIX_W-1:0] lbuf_rd;
    logic [PIX_W-1:0] lbuf [HALF_W];
    logic [LB_AW-1:0] lb_addr;
    logic             col_last;
    logic             row_last;
    logic             col_odd;
    logic             row_odd;

    assign col_last = (col_cnt == COL_W'(IMG_WIDHT - 1));
    assign row_last = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
    assign col_odd  = col_cnt[0];
    assign row_odd  = row_cnt[0];
    assign lb_addr  = LB_AW'(col_cnt >> 1);
    assign lbuf_rd  = lbuf[lb_addr];

    // Horizontal max pairs h_reg with the odd-column pixel; vertical max pairs it with the row above.
    for (genvar k = 0; k < CHANNEL; k++) begin : g_chan
        pool_fp32_max u_hmax (
            .a(h_reg  [k*FP32_W +: FP32_W]),
            .b(Data_In[k*FP32_W +: FP32_W]),
            .y(hmax   [k*FP32_W +: FP32_W])
        );
        pool_fp32_max u_vmax (
            .a(lbuf_rd[k*FP32_W +: FP32_W]),
            .b(hmax   [k*FP32_W +: FP32_W]),
            .y(vmax   [k*FP32_W +: FP32_W])
        );
    end

    // Line buffer has no reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (!rst && Valid_In && col_odd && !row_odd) begin
            lbuf[lb_addr] <= hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            h_reg      <= '0;
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            if (Valid_In) begin
                if (!col_odd) begin
                    h_reg <= Data_In;
                end
                if (col_odd && row_odd) begin
                    Data_Out   <= vmax;
                    Valid_Out  <= 1'b1;
                    Frame_Done <= row_last && col_last;
                end
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end
        end
    end

endmodule
